// File: rtl/fp2fx_pkg.sv
// Shared constants, width helpers and the stage-1 lane record for the
// minifloat-to-fixed converter.
package fp2fx_pkg;

  localparam int DEF_EXP_W  = 4;
  localparam int DEF_MAN_W  = 4;
  localparam int DEF_BIAS   = 8;
  localparam int DEF_INT_W  = 6;
  localparam int DEF_FRAC_W = 11;
  localparam int DEF_LANES  = 1;

  // Fixed magnitude width so the record can be a plain package typedef;
  // any INT_W+FRAC_W up to 31 fits with the separate ovf bit.
  localparam int MAG_W = 32;

  function automatic int fp_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int q_w(input int int_w, input int frac_w);
    return 1 + int_w + frac_w;
  endfunction

  typedef struct packed {
    logic             sign;
    logic             zero;
    logic             ovf;
    logic [MAG_W-1:0] mag;
    logic             guard;
  } lane_rec_t;

endpackage

// File: rtl/fp2fx_lane.sv
// Per-lane combinational logic: minifloat decode/shift into a lane record,
// and round-half-away/saturate of a registered record into signed fixed point.
module fp2fx_lane
  import fp2fx_pkg::*;
#(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int MAN_W  = DEF_MAN_W,
  parameter int BIAS   = DEF_BIAS,
  parameter int INT_W  = DEF_INT_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic [fp_w(EXP_W, MAN_W)-1:0]         fp,
  output lane_rec_t                             rec,
  input  lane_rec_t                             rec_p1,
  output logic signed [q_w(INT_W, FRAC_W)-1:0]  q,
  output logic                                  sat
);

  localparam int FW     = fp_w(EXP_W, MAN_W);
  localparam int QW     = q_w(INT_W, FRAC_W);
  localparam int SH_OFS = FRAC_W - MAN_W - BIAS;

  localparam logic [MAG_W:0] ONE     = 1;
  localparam logic [MAG_W:0] LIM_NEG = ONE << (INT_W + FRAC_W);
  localparam logic [MAG_W:0] LIM_POS = LIM_NEG - ONE;

  function automatic lane_rec_t decode(input logic [FW-1:0] f);
    lane_rec_t        r;
    logic [EXP_W-1:0] e;
    logic [MAN_W:0]   sig;
    logic [63:0]      wide;
    int               sh;
    e    = f[FW-2 -: EXP_W];
    sig  = {1'b1, f[MAN_W-1:0]};
    sh   = int'(e) + SH_OFS;
    r    = '0;
    r.sign = f[FW-1];
    if (e == '0) begin
      r.zero = 1'b1;
    end else if (sh >= 0) begin
      wide  = 64'(sig) << sh;
      r.ovf = (sh > MAG_W) || ((wide >> MAG_W) != 64'd0);
      r.mag = MAG_W'(wide);
    end else begin
      // Extra LSB below the significand becomes the guard bit after the shift.
      wide    = (64'(sig) << 1) >> (-sh);
      r.mag   = MAG_W'(wide >> 1);
      r.guard = wide[0];
    end
    return r;
  endfunction

  function automatic logic [QW:0] round_sat(input lane_rec_t r);
    logic [MAG_W:0]  rnd;
    logic [QW-1:0]   qo;
    logic            so;
    rnd = {1'b0, r.mag} + {{MAG_W{1'b0}}, r.guard};
    qo  = '0;
    so  = 1'b0;
    if (!r.zero) begin
      if (!r.sign) begin
        if (r.ovf || (rnd > LIM_POS)) begin
          qo = QW'(LIM_POS);
          so = 1'b1;
        end else begin
          qo = QW'(rnd);
        end
      end else begin
        if (r.ovf || (rnd > LIM_NEG)) begin
          qo = QW'(-LIM_NEG);
          so = 1'b1;
        end else begin
          qo = QW'(-rnd);
        end
      end
    end
    return {so, qo};
  endfunction

  assign rec      = decode(fp);
  assign {sat, q} = round_sat(rec_p1);

endmodule

// File: rtl/fp_to_fixed_stream.sv
// Two-stage valid/ready minifloat-to-fixed converter with LANES lanes.
// Define FP2FX_STATS_EN to build the saturation counter (sat_cnt/stat_clr).
module fp_to_fixed_stream
  import fp2fx_pkg::*;
#(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int MAN_W  = DEF_MAN_W,
  parameter int BIAS   = DEF_BIAS,
  parameter int INT_W  = DEF_INT_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int LANES  = DEF_LANES
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [LANES*fp_w(EXP_W, MAN_W)-1:0]      in_fp,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [LANES*q_w(INT_W, FRAC_W)-1:0]      out_q,
  output logic [LANES-1:0]                         out_sat,
  input  logic                                     stat_clr,
  output logic [15:0]                              sat_cnt
);

  localparam int FW = fp_w(EXP_W, MAN_W);
  localparam int QW = q_w(INT_W, FRAC_W);

  logic                  vld_p1, vld_p2;
  logic                  adv_p1, adv_p2;
  lane_rec_t             rec_p0 [LANES];
  lane_rec_t             rec_p1 [LANES];
  logic [LANES*QW-1:0]   q_rnd, q_p2;
  logic [LANES-1:0]      sat_rnd, sat_p2;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fp2fx_lane #(
      .EXP_W  (EXP_W),
      .MAN_W  (MAN_W),
      .BIAS   (BIAS),
      .INT_W  (INT_W),
      .FRAC_W (FRAC_W)
    ) u_lane (
      .fp     (in_fp[l*FW +: FW]),
      .rec    (rec_p0[l]),
      .rec_p1 (rec_p1[l]),
      .q      (q_rnd[l*QW +: QW]),
      .sat    (sat_rnd[l])
    );
  end

  assign adv_p2   = !vld_p2 || out_ready;
  assign adv_p1   = !vld_p1 || adv_p2;
  assign in_ready = adv_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      q_p2   <= '0;
      sat_p2 <= '0;
    end else begin
      if (adv_p1) vld_p1 <= in_valid;
      if (adv_p2) vld_p2 <= vld_p1;
      // stage 1 -> stage 2: rounded, saturated, signed result
      if (adv_p2 && vld_p1) begin
        q_p2   <= q_rnd;
        sat_p2 <= sat_rnd;
      end
    end
  end

  // input -> stage 1: magnitude, overflow and guard per lane
  always_ff @(posedge clk) begin
    if (adv_p1 && in_valid) rec_p1 <= rec_p0;
  end

  assign out_valid = vld_p2;
  assign out_q     = q_p2;
  assign out_sat   = sat_p2;

`ifdef FP2FX_STATS_EN
  function automatic logic [15:0] cnt_next(input logic [15:0] c, input logic [LANES-1:0] s);
    logic [16:0] sum;
    sum = {1'b0, c};
    for (int i = 0; i < LANES; i++) sum = sum + 17'(s[i]);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt_q <= '0;
    else if (stat_clr)               cnt_q <= '0;
    else if (out_valid && out_ready) cnt_q <= cnt_next(cnt_q, sat_p2);
  end

  assign sat_cnt = cnt_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign sat_cnt         = '0;
`endif

endmodule

// File: tb/tb_fp_to_fixed_stream.sv
// Directed bench for fp_to_fixed_stream: default E4M4->Q6.11 sweep, saturation,
// backpressure and reset, plus FRAC_W=3 rounding and LANES=4 instances.
module tb_fp_to_fixed_stream;

`ifdef FP2FX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk, rst_n;

  // default instance
  logic        in_valid, in_ready, out_valid, out_ready, stat_clr;
  logic [8:0]  in_fp;
  logic [17:0] out_q;
  logic [0:0]  out_sat;
  logic [15:0] sat_cnt;

  // LANES=4 instance
  logic        in_valid4, in_ready4, out_valid4, out_ready4, stat_clr4;
  logic [35:0] in_fp4;
  logic [71:0] out_q4;
  logic [3:0]  out_sat4;
  logic [15:0] sat_cnt4;

  // FRAC_W=3 instance
  logic        in_valid3, in_ready3, out_valid3, out_ready3, stat_clr3;
  logic [8:0]  in_fp3;
  logic [9:0]  out_q3;
  logic [0:0]  out_sat3;
  logic [15:0] sat_cnt3;

  int checks = 0;
  int errors = 0;

  fp_to_fixed_stream u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_fp(in_fp),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_sat(out_sat),
    .stat_clr(stat_clr), .sat_cnt(sat_cnt)
  );

  fp_to_fixed_stream #(.LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .in_fp(in_fp4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_q(out_q4), .out_sat(out_sat4),
    .stat_clr(stat_clr4), .sat_cnt(sat_cnt4)
  );

  fp_to_fixed_stream #(.FRAC_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .in_fp(in_fp3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_q(out_q3), .out_sat(out_sat3),
    .stat_clr(stat_clr3), .sat_cnt(sat_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Real-valued reference for E4M4 with INT_W=6 and the given FRAC_W.
  function automatic longint model(input int code, input int fw, output bit sat);
    int     e, m, p;
    real    v;
    longint mag, lim;
    e   = (code >> 4) & 15;
    m   = code & 15;
    sat = 1'b0;
    lim = longint'(1) << (6 + fw);
    if (e == 0) return 0;
    v = 1.0 + real'(m) / 16.0;
    p = e - 8 + fw;
    for (int k = 0; k < p; k++) v = v * 2.0;
    for (int k = 0; k > p; k--) v = v / 2.0;
    mag = longint'($floor(v + 0.5));
    if (((code >> 8) & 1) == 1) begin
      if (mag > lim) begin sat = 1'b1; return -lim; end
      return -mag;
    end
    if (mag > lim - 1) begin sat = 1'b1; return lim - 1; end
    return mag;
  endfunction

  task automatic push(input logic [8:0] code);
    @(negedge clk);
    in_valid = 1'b1;
    in_fp    = code;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  longint exp_q[$];
  bit     exp_s[$];
  longint em;
  bit     es;
  int     nsat, received, sent, got;
  logic [8:0] bp [5];
  longint     bp_q [4];
  logic [8:0] c3 [4];
  longint     e3 [4];

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_fp = '0; out_ready = 1'b1; stat_clr = 1'b0;
    in_valid4 = 1'b0; in_fp4 = '0; out_ready4 = 1'b1; stat_clr4 = 1'b0;
    in_valid3 = 1'b0; in_fp3 = '0; out_ready3 = 1'b1; stat_clr3 = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_q", out_q, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // Exhaustive sweep, streaming one beat per cycle
    nsat = 0;
    received = 0;
    for (int i = 0; i < 515; i++) begin
      @(negedge clk);
      if (out_valid) begin
        received++;
        if (exp_q.size() == 0) begin
          check("sweep_extra_beat", 1, 0);
        end else begin
          em = exp_q.pop_front();
          es = exp_s.pop_front();
          check("sweep_q", longint'($signed(out_q)), em);
          check("sweep_sat", out_sat, es);
        end
      end
      if (i < 512) begin
        in_valid = 1'b1;
        in_fp    = 9'(i);
        em = model(i, 11, es);
        if (es) nsat++;
        exp_q.push_back(em);
        exp_s.push_back(es);
      end else begin
        in_valid = 1'b0;
      end
    end
    check("sweep_count", received, 512);
    check("sat_cnt_sweep", sat_cnt, STATS ? nsat : 0);

    @(negedge clk) stat_clr = 1'b1;
    @(negedge clk) stat_clr = 1'b0;
    check("sat_cnt_clr", sat_cnt, 0);

    // Saturation at both ends
    push(9'h0F0);
    @(negedge clk);
    check("sat_pos_q", longint'($signed(out_q)), 131071);
    check("sat_pos_flag", out_sat, 1);
    push(9'h1F0);
    @(negedge clk);
    check("sat_neg_q", longint'($signed(out_q)), -131072);
    check("sat_neg_flag", out_sat, 1);
    @(negedge clk);
    check("sat_cnt_two", sat_cnt, STATS ? 2 : 0);

    push(9'h0F0);
    @(negedge clk);
    check("clr_beat_valid", out_valid, 1);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    check("clr_priority", sat_cnt, 0);
    check("clr_beat_gone", out_valid, 0);

    // Backpressure: out_ready low for 5 cycles, 4 beats offered
    bp[0] = 9'h080; bp[1] = 9'h090; bp[2] = 9'h0A0; bp[3] = 9'h0B0; bp[4] = 9'h000;
    bp_q[0] = 2048; bp_q[1] = 4096; bp_q[2] = 8192; bp_q[3] = 16384;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 4);
      in_fp     = bp[sent];
      #1;
      if (cyc == 2 || cyc == 4) begin
        check("bp_in_ready", in_ready, 0);
        check("bp_accepted", sent, 2);
        check("bp_hold_q", longint'($signed(out_q)), 2048);
      end
      if (out_valid && out_ready) begin
        check("bp_order_q", longint'($signed(out_q)), bp_q[got]);
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_all_received", got, 4);

    // LANES=4 single beat
    @(negedge clk);
    in_valid4 = 1'b1;
    in_fp4    = {9'h0F0, 9'h1A8, 9'h090, 9'h080};
    @(negedge clk);
    in_valid4 = 1'b0;
    check("l4_latency", out_valid4, 0);
    @(negedge clk);
    check("l4_valid", out_valid4, 1);
    check("l4_lane0", longint'($signed(out_q4[17:0])), 2048);
    check("l4_lane1", longint'($signed(out_q4[35:18])), 4096);
    check("l4_lane2", longint'($signed(out_q4[53:36])), -12288);
    check("l4_lane3", longint'($signed(out_q4[71:54])), 131071);
    check("l4_sat", out_sat4, 4'b1000);
    check("l4_in_ready", in_ready4, 1);
    @(negedge clk);
    check("l4_sat_cnt", sat_cnt4, STATS ? 1 : 0);

    // FRAC_W=3 rounding
    c3[0] = 9'h058; c3[1] = 9'h158; c3[2] = 9'h040; c3[3] = 9'h10F;
    e3[0] = 2;      e3[1] = -2;     e3[2] = 1;      e3[3] = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check("f3_valid", out_valid3, 1);
        check("f3_q", longint'($signed(out_q3)), e3[i-2]);
        check("f3_sat", out_sat3, 0);
      end
      in_valid3 = (i < 4);
      in_fp3    = (i < 4) ? c3[i] : 9'h000;
    end
    check("f3_in_ready", in_ready3, 1);
    check("f3_sat_cnt", sat_cnt3, 0);

    // Reset with two beats in flight
    @(negedge clk);
    in_valid = 1'b1; in_fp = 9'h080;
    @(negedge clk);
    in_fp = 9'h090;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_q", out_q, 0);
    check("mid_rst_sat", out_sat, 0);
    check("mid_rst_cnt", sat_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_in_ready", in_ready, 1);
    check("mid_flushed", out_valid, 0);
    in_valid = 1'b1; in_fp = 9'h0A0;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_latency", out_valid, 0);
    @(negedge clk);
    check("mid_valid", out_valid, 1);
    check("mid_q", longint'($signed(out_q)), 8192);
    @(negedge clk);
    check("mid_no_dup", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
